// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory/peripheral bus.
// The granted master's request passes straight through; a per-transaction watchdog forces completion.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // r_last: 1'b0 = master 0 served last, 1'b1 = master 1 served last
    logic [0:0]    r_state;
    logic [1:0]    r_grant;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_timeout_err;

    logic [0:0]    w_nxt_state;
    logic [1:0]    w_nxt_grant;
    logic          w_nxt_last;
    logic [CW-1:0] w_nxt_cnt;
    logic          w_nxt_err;

    logic          w_busy;
    logic          w_sel_m1;
    logic          w_gnt_valid;
    logic          w_done;
    logic          w_tmo;
    logic          w_fin;
    logic          w_abort;
    logic [31:0]   w_rdata;

    // Round-robin pick: a tie goes to the master that was not served last.
    function automatic logic [1:0] f_arbitrate(input logic v0, input logic v1, input logic last);
        logic [1:0] pick;
        if (v0 && v1) begin
            pick = last ? 2'b01 : 2'b10;
        end else if (v0) begin
            pick = 2'b01;
        end else if (v1) begin
            pick = 2'b10;
        end else begin
            pick = 2'b00;
        end
        return pick;
    endfunction

    // Transaction status decode for the current BUSY cycle.
    always_comb begin
        w_busy      = (r_state == ST_BUSY);
        w_sel_m1    = r_grant[1];
        w_gnt_valid = w_busy && (w_sel_m1 ? m1_valid : m0_valid);
        w_done      = w_gnt_valid && s_ready;
        w_tmo       = w_gnt_valid && !s_ready && (r_cnt == CNT_LAST);
        w_fin       = w_done || w_tmo;
        w_abort     = w_busy && !w_gnt_valid;
        w_rdata     = w_tmo ? ERR_RDATA : s_rdata;
    end

    // Slave-side request mux and master-side completion outputs.
    always_comb begin
        s_valid  = w_gnt_valid;
        s_addr   = 32'h0000_0000;
        s_wdata  = 32'h0000_0000;
        s_wstrb  = 4'h0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = 32'h0000_0000;
        m1_rdata = 32'h0000_0000;
        if (w_busy) begin
            if (w_sel_m1) begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end else begin
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
        end else begin
            s_addr = 32'h0000_0000;
        end
        if (w_fin) begin
            if (w_sel_m1) begin
                m1_ready = 1'b1;
                m1_rdata = w_rdata;
            end else begin
                m0_ready = 1'b1;
                m0_rdata = w_rdata;
            end
        end else begin
            m0_ready = 1'b0;
        end
    end

    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;

    // Next-state logic for the arbiter FSM, watchdog counter and error flag.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_last  = r_last;
        w_nxt_cnt   = r_cnt;
        w_nxt_err   = r_timeout_err;
        case (r_state)
            ST_IDLE: begin
                w_nxt_grant = f_arbitrate(m0_valid, m1_valid, r_last);
                if (m0_valid || m1_valid) begin
                    w_nxt_state = ST_BUSY;
                    w_nxt_cnt   = {CW{1'b0}};
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // An abort leaves r_last alone so the aborting master keeps its turn order.
                if (w_abort) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_grant = 2'b00;
                end else if (w_fin) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_grant = 2'b00;
                    w_nxt_last  = w_sel_m1;
                end else if (r_cnt != CNT_MAX) begin
                    w_nxt_cnt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    w_nxt_cnt = r_cnt;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = 2'b00;
                w_nxt_cnt   = {CW{1'b0}};
            end
        endcase
        // A timeout in the same cycle as err_clr keeps the flag set.
        if (w_tmo) begin
            w_nxt_err = 1'b1;
        end else if (err_clr) begin
            w_nxt_err = 1'b0;
        end else begin
            w_nxt_err = r_timeout_err;
        end
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'b00;
            r_last        <= 1'b1;
            r_cnt         <= {CW{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_grant       <= w_nxt_grant;
            r_last        <= w_nxt_last;
            r_cnt         <= w_nxt_cnt;
            r_timeout_err <= w_nxt_err;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master round-robin arbiter that shares the SoC's single memory/peripheral bus between the CPU (master 0) and the AI accelerator DMA (master 1). It uses the native valid/ready memory handshake on both sides. Each granted transaction is passed through to the slave unchanged and held until the slave completes it or a timeout expires. The block sits between the masters and the SOC address decoder (RAM, UART, LED registers).

## Interface
- `TIMEOUT`, default 255: slave cycles allowed per transaction before forced completion; legal range 1..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports (widths per line):
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `resetn`, input, 1: asynchronous active-low reset.
- `m0_valid` / `m1_valid`, input, 1: master N requests a transfer. The master holds it and all its request fields stable until `mN_ready`.
- `m0_addr` / `m1_addr`, input, 32: byte address.
- `m0_wdata` / `m1_wdata`, input, 32: write data.
- `m0_wstrb` / `m1_wstrb`, input, 4: byte write strobes; 0 means a read.
- `m0_ready` / `m1_ready`, output, 1: one-cycle completion pulse to master N.
- `m0_rdata` / `m1_rdata`, output, 32: read data, valid while `mN_ready` is high.
- `s_valid`, output, 1: request to the slave.
- `s_addr`, output, 32: address to the slave.
- `s_wdata`, output, 32: write data to the slave.
- `s_wstrb`, output, 4: write strobes to the slave.
- `s_ready`, input, 1: slave completion.
- `s_rdata`, input, 32: slave read data.
- `grant`, output, 2: one-hot owner of the bus; 2'b00 when idle.
- `timeout_err`, output, 1: sticky flag, set when any transaction times out.
- `err_clr`, input, 1: clears `timeout_err`.

## Operation
- **States:** `IDLE` and `BUSY`. Registers: state, `grant`, `last` (the last master served), the timeout counter, and `timeout_err`.
- **IDLE:**
  - If no `mN_valid` is high, remain in IDLE.
  - If exactly one `mN_valid` is high, grant that master.
  - If both are high, grant the master that is not `last`.
  - On a grant, go to BUSY next cycle and clear the counter.
- **BUSY, request path:**
  - `s_valid` = the granted master's `valid`.
  - `s_addr`, `s_wdata`, `s_wstrb` are combinational muxes of the granted master's fields.
  - The non-granted master sees `mN_ready` = 0.
- **BUSY, completion:**
  - If `s_ready` is high, then `mN_ready` = 1 and `mN_rdata` = `s_rdata` for the granted master, combinationally in the same cycle.
  - Next state is IDLE, `last` becomes the granted master, and `grant` becomes 0.
- **BUSY, waiting:** if `s_ready` is low, the counter increments.
- **BUSY, timeout:**
  - When the counter equals `TIMEOUT - 1` and `s_ready` is low, force completion.
  - `mN_ready` = 1 and `mN_rdata` = `ERR_RDATA`.
  - `timeout_err` is set, the state returns to IDLE, and `last` is updated.
  - Writes are dropped.
- **Abort:** if the granted master deasserts `valid` in BUSY (protocol violation), return to IDLE without issuing `ready`. `last` is not updated.
- **Other output rules:**
  - `mN_rdata` = 0 whenever `mN_ready` is low.
  - `s_*` fields = 0 when idle.
- **`timeout_err` priority:** a set in the same cycle as `err_clr` wins, so the flag stays 1.
- **Counter:** width is `$clog2(TIMEOUT+1)` bits. It saturates and never wraps.

## Timing
- **Reset values** (all asynchronous on `resetn` = 0, including mid-transaction):
  - state = IDLE, `grant` = 0, `last` = master 1 (so master 0 wins the first tie), counter = 0, `timeout_err` = 0.
  - All outputs read 0.
  - An in-flight transaction is abandoned with no `ready` pulse.
- **Arbitration latency:** 1 cycle. `mN_valid` sampled high in IDLE at edge k gives `grant` and `s_valid` from cycle k+1.
- **Minimum transaction:** 2 cycles from request to `mN_ready`, when `s_ready` is high in the first BUSY cycle.
- **Back-to-back:** after completion, one IDLE cycle always precedes the next grant. A master's maximum throughput is therefore one transfer every 2 cycles.
- **Starvation bound:** with both masters continuously requesting, grants alternate m0, m1, m0 … Each master waits at most one foreign transaction (at most `TIMEOUT` + 1 cycles).
- **Timeout:** `ready` is forced on the `TIMEOUT`-th BUSY cycle. With `TIMEOUT` = 1, the first BUSY cycle with `s_ready` low times out.
- **`s_ready` outside BUSY** is ignored.

## Test plan
- **Single read:** reset, then `m0_valid` with addr 0x0000_0010, wstrb 0; slave returns `s_rdata` = 0x1234_5678 with `s_ready` in the first BUSY cycle. Required: `grant` = 01, `m0_ready` pulses one cycle, 2 cycles after the request, with `m0_rdata` = 0x1234_5678; `m1_ready` stays 0.
- **Tie after reset:** `m0_valid` and `m1_valid` rise in the same cycle; slave has 1-cycle latency. Required: grants m0 then m1, one IDLE cycle between them; `s_addr` matches each master.
- **Sustained contention:** both masters request continuously for 6 transfers. Required: `grant` sequence 01, 10, 01, 10, 01, 10.
- **Timeout:** `TIMEOUT` = 4, slave never asserts `s_ready`, m1 write. Required: `m1_ready` on the 4th BUSY cycle with `m1_rdata` = 0xDEAD_BEEF; `timeout_err` = 1 and held. Pulsing `err_clr` clears it.
- **Mid-operation reset:** m0 granted with slave stalled; `resetn` pulsed low for 1 cycle. Required: `grant`, `s_valid` and `m0_ready` go to 0 immediately, with no `ready` pulse; the next tie is won by m0.
- **Abort:** m1 granted, then `m1_valid` drops before `s_ready`. Required: return to IDLE and no `m1_ready`; the next tie grants m0 because `last` is unchanged.
